mult_div: RTL
=============

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have port: clock  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-003 SHALL have port: start_mult  in  1  one-cycle request from control FSM for signed 32x32 multiply.
REQ-004 SHALL have port: start_div  in  1  one-cycle request from control FSM for signed 32/32 divide.
REQ-005 SHALL have port: A  in  32  multiplicand / dividend, from A register.
REQ-006 SHALL have port: B  in  32  multiplier / divisor, from B register.
REQ-007 SHALL have port: HI  out  32  product[63:32] or remainder, registered.
REQ-008 SHALL have port: LO  out  32  product[31:0] or quotient, registered.
REQ-009 SHALL have port: busy  out  1  high while an operation is in progress, including the DONE cycle.
REQ-010 SHALL have port: done  out  1  single-cycle completion pulse.
REQ-011 SHALL have port: div_zero  out  1  high with done when the divisor was zero.

Function
REQ-012 SHALL implement states IDLE, MULT, DIV, DONE.
REQ-013 SHALL, in IDLE on edge N with start_mult=1, capture A and B, clear the iteration counter and go to MULT.
REQ-014 SHALL, in IDLE with start_div=1 and start_mult=0, capture operands and go to DIV; start_mult SHALL win when both are high.
REQ-015 SHALL ignore start_mult and start_div in every state other than IDLE, and SHALL ignore changes on A/B after capture.
REQ-016 SHALL perform exactly one radix-2 Booth step per cycle in MULT, on edges N+1..N+32 (6-bit counter 0..31).
REQ-017 SHALL perform exactly one restoring-division step per cycle on operand magnitudes in DIV, on edges N+1..N+32.
REQ-018 SHALL give a quotient that is negative iff operand signs differ, and a remainder with the sign of the dividend (truncating division, MIPS DIV).
REQ-019 SHALL, for 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0 with no flag.
REQ-020 SHALL write HI/LO on edge N+32, enter DONE, and drive done=1 for that one cycle only.
REQ-021 SHALL return from DONE to IDLE on the next edge (N+33) with done=0 and busy=0; a start sampled on edge N+33 SHALL be accepted.
REQ-022 SHALL drive busy=1 from edge N through edge N+33.
REQ-023 SHALL, for start_div with B=0, skip iteration, go to DONE on edge N+1, assert done and div_zero together, and leave HI/LO unchanged.
REQ-024 SHALL hold HI/LO stable at all times except on the completion edge.
REQ-025 SHALL drive div_zero=0 whenever done=0.

Reset
REQ-026 SHALL, on any edge with reset=1, enter IDLE and clear HI, LO, busy, done, div_zero, the counter and the internal operand registers, including mid-operation.
REQ-027 SHALL ignore start inputs that are sampled on the same edge as reset=1.

Configuration
REQ-028 SHALL compile the divider in when macro MULT_DIV_DIVIDER_EN is defined, with behaviour as in REQ-014, REQ-017..REQ-019 and REQ-023.
REQ-029 SHALL, without MULT_DIV_DIVIDER_EN, omit the DIV state and divider logic, treat start_div as a no-op (stay in IDLE, no done), and tie div_zero to 0; multiply SHALL be unaffected.

Verification
REQ-030 SHALL cover: start_mult, A=7, B=0xFFFFFFFD -> done on edge N+32, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-031 SHALL cover: start_mult, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000; busy high for edges N..N+33.
REQ-032 SHALL cover: start_div, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL cover: start_div, A=5, B=0 -> done and div_zero both high on the cycle after edge N+1, HI/LO keep their prior values.
REQ-034 SHALL cover: reset at edge N+10 of a multiply -> IDLE, all outputs 0, no done pulse; a new start_mult on the next edge completes correctly.
REQ-035 SHALL cover: start_mult and start_div high together with A=3, B=4 -> multiply performed, HI=0, LO=12; a start pulsed during busy has no effect.

Source files
------------

// File: rtl/mult_div.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and optional restoring divider.
// Define MULT_DIV_DIVIDER_EN to build in the divider; without it start_div is a no-op.
module mult_div (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

`ifdef MULT_DIV_DIVIDER_EN
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
`endif

    state_t      state, next_state;
    logic [5:0]  count;
    logic [31:0] mcand;
    logic [33:0] acc;
    logic [31:0] q;
    logic        q_m1;
    logic        last_step;

    logic [33:0] mcand_ext;
    logic [33:0] booth_sum;
    logic [33:0] booth_acc;
    logic [31:0] booth_q;

    assign last_step = (count == 6'd31);
    assign mcand_ext = {{2{mcand[31]}}, mcand};

    // Accumulator carries two guard bits so subtracting -2^31 cannot overflow.
    always_comb begin
        booth_sum = acc;
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + mcand_ext;
            2'b10:   booth_sum = acc - mcand_ext;
            default: booth_sum = acc;
        endcase
        booth_acc = {booth_sum[33], booth_sum[33:1]};
        booth_q   = {booth_sum[0], q[31:1]};
    end

`ifdef MULT_DIV_DIVIDER_EN
    logic        quo_neg;
    logic        rem_neg;
    logic        dz_flag;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] rem_final;
    logic [31:0] quo_final;

    assign a_mag = A[31] ? (~A + 32'd1) : A;
    assign b_mag = B[31] ? (~B + 32'd1) : B;

    // Divide reuses acc[31:0] as remainder, q as dividend/quotient, mcand as |divisor|.
    always_comb begin
        div_shift = {acc[31:0], q[31]};
        div_diff  = div_shift - {1'b0, mcand};
        div_ge    = ~div_diff[32];
        div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];
        div_quo   = {q[30:0], div_ge};
        rem_final = rem_neg ? (~div_rem + 32'd1) : div_rem;
        quo_final = quo_neg ? (~div_quo + 32'd1) : div_quo;
    end

    assign div_zero = done & dz_flag;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mult) begin
                    next_state = MULT;
                end
`ifdef MULT_DIV_DIVIDER_EN
                else if (start_div) begin
                    next_state = DIV;
                end
`endif
            end
            MULT: begin
                if (last_step) begin
                    next_state = DONE;
                end
            end
`ifdef MULT_DIV_DIVIDER_EN
            DIV: begin
                if (dz_flag || last_step) begin
                    next_state = DONE;
                end
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            HI    <= 32'd0;
            LO    <= 32'd0;
            count <= 6'd0;
            mcand <= 32'd0;
            acc   <= 34'd0;
            q     <= 32'd0;
            q_m1  <= 1'b0;
`ifdef MULT_DIV_DIVIDER_EN
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        mcand <= A;
                        q     <= B;
                        acc   <= 34'd0;
                        q_m1  <= 1'b0;
                        count <= 6'd0;
`ifdef MULT_DIV_DIVIDER_EN
                        dz_flag <= 1'b0;
`endif
                    end
`ifdef MULT_DIV_DIVIDER_EN
                    else if (start_div) begin
                        mcand   <= b_mag;
                        q       <= a_mag;
                        acc     <= 34'd0;
                        q_m1    <= 1'b0;
                        count   <= 6'd0;
                        quo_neg <= A[31] ^ B[31];
                        rem_neg <= A[31];
                        dz_flag <= (B == 32'd0);
                    end
`endif
                end
                MULT: begin
                    acc   <= booth_acc;
                    q     <= booth_q;
                    q_m1  <= q[0];
                    count <= count + 6'd1;
                    if (last_step) begin
                        HI <= booth_acc[31:0];
                        LO <= booth_q;
                    end
                end
`ifdef MULT_DIV_DIVIDER_EN
                DIV: begin
                    if (!dz_flag) begin
                        acc   <= {2'b00, div_rem};
                        q     <= div_quo;
                        count <= count + 6'd1;
                        if (last_step) begin
                            HI <= rem_final;
                            LO <= quo_final;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
